vga_sync_monitor: RTL and testbench
===================================

Name: vga_sync_monitor

Overview:
- Receiving end of the VGA timing interface: consumes hsync/vsync from a 640x480@60 timing source in the same clock domain.
- Recovers pixel position, declares lock once the timing matches the configured mode, and flags timing violations.
- Used on-chip as a self-check behind the timing generator, and in simulation as the protocol checker.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_SYNC_START, 656, x of the first hsync-low pixel
- H_SYNC_WIDTH, 96, hsync low duration in clocks
- H_TOTAL, 800, clocks per line
- V_VISIBLE, 480, visible lines
- V_SYNC_START, 490, y of the first vsync-low line
- V_SYNC_WIDTH, 2, vsync low duration in lines
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive verified vsync falls required for lock

Ports:
- clk_i  in  1  pixel clock
- rst_ni  in  1  synchronous active-low reset
- hsync_i  in  1  horizontal sync, active low
- vsync_i  in  1  vertical sync, active low
- locked_o  out  1  timing recovered and verified
- visible_o  out  1  locked_o && x<H_VISIBLE && y<V_VISIBLE
- position_x_o  out  10  recovered x
- position_y_o  out  10  recovered y
- error_o  out  1  one-cycle pulse on violation while locked
- err_code_o  out  3  cause of the last error_o; held until next error
- error_count_o  out  8  see Optional Feature

Behaviour:
- Inputs are used unsynchronised. hs_q and vs_q are 1-cycle delayed copies. hfall = hs_q & ~hsync_i; hrise = ~hs_q & hsync_i; vfall and vrise are formed the same way.
- Counters x_q (0..H_TOTAL-1) and y_q (0..V_TOTAL-1) are free-running.
  - x wraps to 0 after H_TOTAL-1.
  - y increments on each x wrap and wraps after V_TOTAL-1.
  - Outputs take x_q and y_q directly, so when locked they equal the source's counters in the same cycle.
- Reset: state=SEARCH, x_q=y_q=0, hs_q=vs_q=1, lock_cnt=0, locked_o=0, error_o=0, err_code_o=NONE, error_count_o=0.
- Expected events:
  - hfall exactly when x_q==H_SYNC_START.
  - hrise exactly when x_q==H_SYNC_START+H_SYNC_WIDTH.
  - vfall exactly when x_q==0 && y_q==V_SYNC_START.
  - vrise exactly when x_q==0 && y_q==V_SYNC_START+V_SYNC_WIDTH.
- Violations: an edge at the wrong time, or no edge at the expected time. Classes are H_PERIOD (fall), H_WIDTH (rise), V_PERIOD (vfall), V_WIDTH (vrise).
- FSM:
  - SEARCH: ignore all checks. On hfall, x_q<=H_SYNC_START+1 and go to H_ACQ.
  - H_ACQ: horizontal checks active. Any H violation returns to SEARCH. On vfall, y_q<=V_SYNC_START, lock_cnt<=0, go to V_ACQ.
  - V_ACQ: all checks active. Any violation returns to SEARCH. Each correct vfall increments lock_cnt. When lock_cnt reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: locked_o=1. Any violation causes:
    - error_o=1 for one cycle;
    - err_code_o updated;
    - next state SEARCH, with locked_o low the following cycle.
- Simultaneous violations in one cycle: single error_o. Code priority is H_PERIOD > H_WIDTH > V_PERIOD > V_WIDTH.
- err_code encoding: NONE=0, H_PERIOD=1, H_WIDTH=2, V_PERIOD=3, V_WIDTH=4.
- Reset asserted in any state returns all registers to reset values on that edge. Counters are not cleared on SEARCH entry.
- No errors are reported outside LOCKED; acquisition failures restart silently.

Optional Feature:
- Macro: VGA_MONITOR_ERR_COUNT_EN.
- Defined: error_count_o is an 8-bit saturating count of error_o pulses since reset. It saturates at 255 and is cleared only by reset.
- Undefined: error_count_o is tied to 0 and no counter register exists.

Decomposition:
- Package vga_pkg holds:
  - the 640x480 timing localparams, shared with the timing generator;
  - typedef enum logic [1:0] monitor_state_e {SEARCH, H_ACQ, V_ACQ, LOCKED};
  - typedef enum logic [2:0] sync_err_e.
- One sub-module, sync_edge_det: registers one sync line and produces fall/rise pulses. It is instanced twice.

Test Plan:
- Drive directly from the 640x480 timing generator; both blocks leave reset in the same cycle (source h=v=0 at cycle 0).
  - The hfall at cycle 656 enters H_ACQ.
  - vfall at cycle 392000 enters V_ACQ.
  - Verified vfalls at 812000 and 1232000 set locked_o=1 from cycle 1232001.
  - Thereafter position_x_o/position_y_o/visible_o match the source every cycle.
- Locked; stretch hsync low until x=760 (hrise missing at 752) -> error_o at x=752, err_code_o=2, locked_o=0 next cycle.
- Locked; suppress one vsync pulse -> error_o at y=490,x=0 with err_code_o=3. Relock after LOCK_FRAMES+1 further frames.
- Locked; inject a 1-clock hsync-low glitch at x=100 -> hfall at x=100 gives err_code_o=1. The simultaneous-priority rule is checked by also glitching vsync in the same cycle (code stays 1).
- Assert rst_ni=0 for 1 cycle mid-frame while locked -> next cycle locked_o=0, positions 0, err_code_o=0. Relocks per scenario 1 timing offset.
- With VGA_MONITOR_ERR_COUNT_EN, force 300 errors -> error_count_o saturates at 255. Without the macro -> constant 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and the sync monitor's state/error types.
package vga_pkg;

    localparam int unsigned H_VISIBLE    = 640;
    localparam int unsigned H_SYNC_START = 656;
    localparam int unsigned H_SYNC_WIDTH = 96;
    localparam int unsigned H_TOTAL      = 800;
    localparam int unsigned V_VISIBLE    = 480;
    localparam int unsigned V_SYNC_START = 490;
    localparam int unsigned V_SYNC_WIDTH = 2;
    localparam int unsigned V_TOTAL      = 525;
    localparam int unsigned LOCK_FRAMES  = 2;

    typedef enum logic [1:0] {SEARCH, H_ACQ, V_ACQ, LOCKED} monitor_state_e;

    typedef enum logic [2:0] {
        NONE     = 3'd0,
        H_PERIOD = 3'd1,
        H_WIDTH  = 3'd2,
        V_PERIOD = 3'd3,
        V_WIDTH  = 3'd4
    } sync_err_e;

endpackage

// File: rtl/sync_edge_det.sv
// Registers one active-low sync line and flags its falling and rising edges.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sync_i,
    output logic fall_o,
    output logic rise_o
);

    logic sync_q;

    // Idle-high reset value so a line held high out of reset yields no edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= 1'b1;
        end else begin
            sync_q <= sync_i;
        end
    end

    assign fall_o = sync_q & ~sync_i;
    assign rise_o = ~sync_q & sync_i;

endmodule

// File: rtl/vga_sync_monitor.sv
// Recovers VGA pixel position from hsync/vsync, locks to the configured mode and flags violations.
// Define VGA_MONITOR_ERR_COUNT_EN to get a saturating error counter on error_count_o.
module vga_sync_monitor #(
    parameter int unsigned H_VISIBLE    = vga_pkg::H_VISIBLE,
    parameter int unsigned H_SYNC_START = vga_pkg::H_SYNC_START,
    parameter int unsigned H_SYNC_WIDTH = vga_pkg::H_SYNC_WIDTH,
    parameter int unsigned H_TOTAL      = vga_pkg::H_TOTAL,
    parameter int unsigned V_VISIBLE    = vga_pkg::V_VISIBLE,
    parameter int unsigned V_SYNC_START = vga_pkg::V_SYNC_START,
    parameter int unsigned V_SYNC_WIDTH = vga_pkg::V_SYNC_WIDTH,
    parameter int unsigned V_TOTAL      = vga_pkg::V_TOTAL,
    parameter int unsigned LOCK_FRAMES  = vga_pkg::LOCK_FRAMES
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       hsync_i,
    input  logic       vsync_i,
    output logic       locked_o,
    output logic       visible_o,
    output logic [9:0] position_x_o,
    output logic [9:0] position_y_o,
    output logic       error_o,
    output logic [2:0] err_code_o,
    output logic [7:0] error_count_o
);

    import vga_pkg::*;

    localparam logic [9:0] HVis       = 10'(H_VISIBLE);
    localparam logic [9:0] HSyncStart = 10'(H_SYNC_START);
    localparam logic [9:0] HSyncEnd   = 10'(H_SYNC_START + H_SYNC_WIDTH);
    localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
    localparam logic [9:0] VVis       = 10'(V_VISIBLE);
    localparam logic [9:0] VSyncStart = 10'(V_SYNC_START);
    localparam logic [9:0] VSyncEnd   = 10'(V_SYNC_START + V_SYNC_WIDTH);
    localparam logic [9:0] VLast      = 10'(V_TOTAL - 1);
    localparam logic [7:0] LockTarget = 8'(LOCK_FRAMES);

    logic hfall, hrise, vfall, vrise;

    sync_edge_det u_hsync_det (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .sync_i (hsync_i),
        .fall_o (hfall),
        .rise_o (hrise)
    );

    sync_edge_det u_vsync_det (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .sync_i (vsync_i),
        .fall_o (vfall),
        .rise_o (vrise)
    );

    monitor_state_e state_q, state_d;
    logic [9:0]     x_q, x_d, y_q, y_d;
    logic [7:0]     lock_cnt_q, lock_cnt_d;
    sync_err_e      err_code_q, err_cause;
    logic           h_per_err, h_wid_err, v_per_err, v_wid_err, h_err, v_err;
    logic           err_pulse;

    // An edge where none is expected and a missing expected edge are both violations.
    assign h_per_err = hfall != (x_q == HSyncStart);
    assign h_wid_err = hrise != (x_q == HSyncEnd);
    assign v_per_err = vfall != ((x_q == '0) && (y_q == VSyncStart));
    assign v_wid_err = vrise != ((x_q == '0) && (y_q == VSyncEnd));
    assign h_err     = h_per_err | h_wid_err;
    assign v_err     = v_per_err | v_wid_err;

    always_comb begin
        err_cause = NONE;
        if (h_per_err) begin
            err_cause = H_PERIOD;
        end else if (h_wid_err) begin
            err_cause = H_WIDTH;
        end else if (v_per_err) begin
            err_cause = V_PERIOD;
        end else if (v_wid_err) begin
            err_cause = V_WIDTH;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        err_pulse  = 1'b0;
        x_d        = (x_q == HLast) ? '0 : x_q + 10'd1;
        y_d        = y_q;
        if (x_q == HLast) begin
            y_d = (y_q == VLast) ? '0 : y_q + 10'd1;
        end
        unique case (state_q)
            SEARCH: begin
                if (hfall) begin
                    x_d     = HSyncStart + 10'd1;
                    state_d = H_ACQ;
                end
            end
            H_ACQ: begin
                if (h_err) begin
                    state_d = SEARCH;
                end else if (vfall) begin
                    y_d        = VSyncStart;
                    lock_cnt_d = '0;
                    state_d    = V_ACQ;
                end
            end
            V_ACQ: begin
                if (h_err || v_err) begin
                    state_d = SEARCH;
                end else if (vfall) begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                    if (lock_cnt_d == LockTarget) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (h_err || v_err) begin
                    err_pulse = 1'b1;
                    state_d   = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= SEARCH;
            x_q        <= '0;
            y_q        <= '0;
            lock_cnt_q <= '0;
            err_code_q <= NONE;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            lock_cnt_q <= lock_cnt_d;
            if (err_pulse) begin
                err_code_q <= err_cause;
            end
        end
    end

    assign locked_o     = (state_q == LOCKED);
    assign visible_o    = locked_o && (x_q < HVis) && (y_q < VVis);
    assign position_x_o = x_q;
    assign position_y_o = y_q;
    assign error_o      = err_pulse;
    // The cause is visible in the same cycle as the pulse, then held.
    assign err_code_o   = err_pulse ? err_cause : err_code_q;

`ifdef VGA_MONITOR_ERR_COUNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else if (err_pulse && (err_cnt_q != 8'hff)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign error_count_o = err_cnt_q;
`else
    assign error_count_o = '0;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor on a reduced 12x5 timing mode (60 clocks per frame).
module tb_vga_sync_monitor;

    localparam int HV = 6, HSS = 7, HSW = 2, HT = 12;
    localparam int VV = 2, VSS = 3, VSW = 1, VT = 5;

    typedef struct {
        int cyc;
        int code;
        int x;
        int y;
    } err_exp_t;

    logic       clk, rst_ni, hsync, vsync;
    logic       locked_o, visible_o, error_o;
    logic [9:0] position_x_o, position_y_o;
    logic [2:0] err_code_o;
    logic [7:0] error_count_o;

    int cyc, sx, sy;
    int checks = 0;
    int errors = 0;
    bit run = 0;

    err_exp_t err_q[$];
    int       lock_q[$];
    int       rst_q[$];

    vga_sync_monitor #(
        .H_VISIBLE    (HV),
        .H_SYNC_START (HSS),
        .H_SYNC_WIDTH (HSW),
        .H_TOTAL      (HT),
        .V_VISIBLE    (VV),
        .V_SYNC_START (VSS),
        .V_SYNC_WIDTH (VSW),
        .V_TOTAL      (VT),
        .LOCK_FRAMES  (2)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .hsync_i       (hsync),
        .vsync_i       (vsync),
        .locked_o      (locked_o),
        .visible_o     (visible_o),
        .position_x_o  (position_x_o),
        .position_y_o  (position_y_o),
        .error_o       (error_o),
        .err_code_o    (err_code_o),
        .error_count_o (error_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_err(input int c, input int code, input int x, input int y);
        err_exp_t e;
        e.cyc  = c;
        e.code = code;
        e.x    = x;
        e.y    = y;
        err_q.push_back(e);
    endtask

    // Reference timing source: one pixel per clock, sync levels from its own counters.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        sx    = cyc % HT;
        sy    = (cyc / HT) % VT;
        hsync = !(sx >= HSS && sx < HSS + HSW);
        vsync = !(sy >= VSS && sy < VSS + VSW);
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    // Monitor / scoreboard
    bit       locked_prev = 1'b0;
    bit       after_err   = 1'b0;
    int       after_code  = 0;
    int       exp_cnt     = 0;
    err_exp_t e;
    bit       exp_vis;

    always @(negedge clk) begin
        if (run) begin
            if (rst_q.size() > 0 && rst_q[0] == cyc) begin
                void'(rst_q.pop_front());
                chk("reset_state", {locked_o, error_o, err_code_o, position_x_o, position_y_o,
                                    error_count_o}, 64'd0);
                exp_cnt = 0;
            end
            if (after_err) begin
                chk("lock_drop", locked_o, 0);
                chk("code_held", err_code_o, after_code);
                after_err = 1'b0;
            end
            if (locked_o) begin
                exp_vis = (sx < HV) && (sy < VV);
                chk("track", {position_x_o, position_y_o, visible_o},
                    {10'(sx), 10'(sy), exp_vis});
            end else begin
                chk("visible_unlocked", visible_o, 0);
            end
            if (locked_o && !locked_prev) begin
                if (lock_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_lock: got lock at cycle %0d, expected none", cyc);
                end else begin
                    chk("lock_cycle", cyc, lock_q.pop_front());
                end
            end
            if (error_o) begin
                if (err_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_error: got error_o code %0d at cycle %0d, expected none",
                             err_code_o, cyc);
                end else begin
                    e = err_q.pop_front();
                    chk("err_cycle", cyc, e.cyc);
                    chk("err_code", err_code_o, e.code);
                    chk("err_pos", {position_x_o, position_y_o}, {10'(e.x), 10'(e.y)});
                    chk("err_count", error_count_o, exp_cnt);
`ifdef VGA_MONITOR_ERR_COUNT_EN
                    if (exp_cnt < 255) exp_cnt++;
`endif
                    after_err  = 1'b1;
                    after_code = e.code;
                end
            end
            locked_prev = locked_o;
        end
    end

    // Stimulus
    initial begin
        int g;
        rst_ni = 1'b0;
        hsync  = 1'b1;
        vsync  = 1'b1;
        cyc    = 0;
        sx     = 0;
        sy     = 0;
        rst_q.push_back(0);
        rst_q.push_back(797);
        lock_q.push_back(157);   // vfalls at 36 (acquire), 96, 156
        lock_q.push_back(337);   // after stretched hsync
        lock_q.push_back(577);   // LOCK_FRAMES+1 frames after missing vsync
        lock_q.push_back(757);   // after glitch
        lock_q.push_back(937);   // after mid-frame reset
        push_err(201, 2, 9, 1);  // hrise missing at x=9
        push_err(396, 3, 0, 3);  // vsync pulse suppressed
        push_err(602, 1, 2, 0);  // h+v glitch, H_PERIOD wins
        repeat (3) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        run    = 1'b1;

        // hsync held low one extra clock on line 1 of frame 3
        run_to(201);
        hsync = 1'b0;

        // whole vsync pulse of frame 6 suppressed
        run_to(396);
        vsync = 1'b1;
        while (cyc < 396 + HT - 1) begin
            step();
            vsync = 1'b1;
        end

        // simultaneous 1-clock hsync and vsync glitch
        run_to(602);
        hsync = 1'b0;
        vsync = 1'b0;

        // one-cycle reset while locked, source keeps running
        run_to(796);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;

`ifdef VGA_MONITOR_ERR_COUNT_EN
        // 300 lock/glitch rounds; each relocks 179 clocks after its glitch
        for (int k = 0; k < 300; k++) begin
            g = 938 + 180 * k;
            run_to(g);
            push_err(g, 1, 2, 3);
            lock_q.push_back(g + 179);
            hsync = 1'b0;
        end
        run_to(938 + 180 * 299 + 179 + 10);
        @(negedge clk);
        chk("final_err_count", error_count_o, 255);
`else
        g = 967;
        run_to(g);
        @(negedge clk);
        chk("final_err_count", error_count_o, 0);
`endif
        chk("pending_errors", err_q.size(), 0);
        chk("pending_locks", lock_q.size(), 0);
        chk("pending_resets", rst_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
